raster_scheduler: RTL

//  Frame-level sequencer in front of rasterizer_unit and the GPU write port of frame_buffer_top, on gpu_clk_150.

---
 rtl/raster_scheduler.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/raster_scheduler.sv
// Frame-level sequencer: buffers triangles, optionally clears the frame buffer,
// then hands triangles one at a time to the rasterizer and muxes the FB write port.
module raster_scheduler #(
  parameter int DEPTH = 8,
  parameter int FB_W  = 640,
  parameter int FB_H  = 480
) (
  input  logic                     clk,
  input  logic                     areset_n,
  input  logic                     tri_valid,
  output logic                     tri_ready,
  input  logic [2:0][31:0]         tri_p1,
  input  logic [2:0][31:0]         tri_p2,
  input  logic [2:0][31:0]         tri_p3,
  output logic [$clog2(DEPTH):0]   tri_count,
  input  logic                     frame_start,
  input  logic                     clear_en,
  input  logic [3:0]               clear_color,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     ru_start,
  output logic [2:0][31:0]         ru_p1,
  output logic [2:0][31:0]         ru_p2,
  output logic [2:0][31:0]         ru_p3,
  input  logic                     ru_done,
  input  logic [9:0]               ru_fb_x,
  input  logic [9:0]               ru_fb_y,
  input  logic [3:0]               ru_fb_data,
  input  logic                     ru_fb_we,
  output logic [9:0]               fb_x,
  output logic [9:0]               fb_y,
  output logic [3:0]               fb_data,
  output logic                     fb_we
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = 288;
  localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
  localparam logic [9:0]  X_LAST = 10'(FB_W - 1);
  localparam logic [9:0]  Y_LAST = 10'(FB_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic [9:0]      cx;
  logic [9:0]      cy;
  logic            clear_last;

  assign tri_ready  = (tri_count != FULL);
  assign fifo_empty = (tri_count == '0);
  assign push       = tri_valid & tri_ready;
  assign pop        = (state == S_ISSUE) & ~fifo_empty;
  assign clear_last = (cx == X_LAST) && (cy == Y_LAST);

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      tri_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   tri_count <= tri_count + 1'b1;
        2'b01:   tri_count <= tri_count - 1'b1;
        default: tri_count <= tri_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {tri_p3, tri_p2, tri_p1};
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      ru_p1 <= '0;
      ru_p2 <= '0;
      ru_p3 <= '0;
    end else if (pop) begin
      {ru_p3, ru_p2, ru_p1} <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cx <= '0;
      cy <= '0;
    end else if (state == S_CLEAR) begin
      if (cx == X_LAST) begin
        cx <= '0;
        cy <= (cy == Y_LAST) ? '0 : cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (frame_start) state_nxt = clear_en ? S_CLEAR : S_ISSUE;
      S_CLEAR: if (clear_last)  state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = fifo_empty ? S_DONE : S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (ru_done)     state_nxt = S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    ru_start   = (state == S_START);
    frame_done = (state == S_DONE);
    if (state == S_CLEAR) begin
      fb_we   = 1'b1;
      fb_x    = cx;
      fb_y    = cy;
      fb_data = clear_color;
    end else begin
      fb_we   = ru_fb_we;
      fb_x    = ru_fb_x;
      fb_y    = ru_fb_y;
      fb_data = ru_fb_data;
    end
  end

endmodule
